// File: rtl/reg_file_mp.sv
// Multi-read-port MIPS register file: hardwired-zero r0, sequenced post-reset clear,
// registered debug port and dropped-write reporting. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file_mp #(
    parameter int WIDTH         = 32,
    parameter int WIDTH_ADD     = 5,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_RD_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            we,
    input  logic [WIDTH_ADD-1:0]            waddr,
    input  logic [WIDTH-1:0]                wdata,
    input  logic [NUM_RD_PORTS*WIDTH_ADD-1:0] raddr,
    output logic [NUM_RD_PORTS*WIDTH-1:0]   rdata,
    input  logic [WIDTH_ADD-1:0]            dbg_addr,
    output logic [WIDTH-1:0]                dbg_data,
    output logic                            clear_busy,
    output logic                            wr_err
);

    localparam int CW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam logic [CW-1:0]        LAST = CW'(NUM_REGISTERS - 1);
    localparam logic [WIDTH_ADD:0]   NREG = (WIDTH_ADD + 1)'(NUM_REGISTERS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] regs [NUM_REGISTERS];
    logic             waddr_in_range;
    logic             write_ok;
    logic             write_drop;

    function automatic logic in_range(input logic [WIDTH_ADD-1:0] a);
        return {1'b0, a} < NREG;
    endfunction

    // r0, out-of-range addresses and the clear window all read as zero.
    function automatic logic [WIDTH-1:0] masked_read(input logic [WIDTH_ADD-1:0] a);
        if (state == CLEAR || a == '0 || !in_range(a))
            return '0;
        return regs[a[CW-1:0]];
    endfunction

    assign waddr_in_range = in_range(waddr);
    assign write_ok   = !reset && we && state == READY && waddr != '0 && waddr_in_range;
    assign write_drop = we && (state == CLEAR || !waddr_in_range);
    assign clear_busy = (state == CLEAR);

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cnt == LAST) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state == CLEAR)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                regs[cnt] <= '0;
            else if (write_ok)
                regs[waddr[CW-1:0]] <= wdata;
        end
    end

    // Debug port samples the array before this edge's write and never bypasses.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_data <= '0;
            wr_err   <= 1'b0;
        end else begin
            dbg_data <= masked_read(dbg_addr);
            wr_err   <= write_drop;
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
            rdata[k*WIDTH +: WIDTH] = masked_read(raddr[k*WIDTH_ADD +: WIDTH_ADD]);
`ifdef REG_FILE_BYPASS_EN
            if (write_ok && raddr[k*WIDTH_ADD +: WIDTH_ADD] == waddr)
                rdata[k*WIDTH +: WIDTH] = wdata;
`endif
        end
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the MIPS datapath, the successor of the 2-read/1-write register file. It adds a configurable number of read ports, a hardwired-zero register 0, a sequenced post-reset clear with a busy flag, a registered debug read port and write-error reporting. It sits between decode, which reads operands, and writeback, which writes results. A compile-time option adds same-cycle write-to-read bypass.

## Interface
- WIDTH, 32, data word width.
- WIDTH_ADD, 5, register address width.
- NUM_REGISTERS, 32, implemented registers; must satisfy 2 ≤ NUM_REGISTERS ≤ 2^WIDTH_ADD.
- NUM_RD_PORTS, 2, number of combinational read ports (1..4).

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- we  input  1  write enable.
- waddr  input  WIDTH_ADD  write address.
- wdata  input  WIDTH  write data.
- raddr  input  NUM_RD_PORTS*WIDTH_ADD  read addresses, flattened; port k occupies bits [k*WIDTH_ADD +: WIDTH_ADD].
- rdata  output  NUM_RD_PORTS*WIDTH  read data, flattened the same way.
- dbg_addr  input  WIDTH_ADD  debug read address.
- dbg_data  output  WIDTH  registered debug read data.
- clear_busy  output  1  high while the post-reset clear sequence runs.
- wr_err  output  1  one-cycle pulse flagging a dropped write.

## Operation
- State machine with two states, CLEAR and READY. clear_busy = (state == CLEAR).
- Reset edge: state ← CLEAR, clear counter ← 0, dbg_data ← 0, wr_err ← 0.
- CLEAR, reset low: registers[cnt] ← 0 and cnt ← cnt+1 on each edge.
  - The edge that clears register NUM_REGISTERS-1 moves the state to READY.
- CLEAR, reset high: the counter holds at 0.
- Reset asserted mid-clear restarts the sequence at 0.
- Reads are combinational: rdata[k] = registers[raddr[k]].
  - Returns 0 when raddr[k] == 0, when raddr[k] ≥ NUM_REGISTERS, or while clear_busy is high.
- Writes in READY: registers[waddr] ← wdata on the edge when we=1, 0 < waddr < NUM_REGISTERS.
- Writes to address 0 are silently discarded; no error.
- Dropped writes: we=1 during CLEAR, or we=1 with waddr ≥ NUM_REGISTERS.
  - The array is unchanged and wr_err = 1 for the following cycle.
- Debug port: dbg_data ← (same masking as the read ports applied to dbg_addr) on each edge.
  - The debug port never bypasses.
- Multiple read ports on the same address return identical data.

## Timing
- Read latency 0 cycles (combinational from raddr and array state).
- Write visible on read ports from the cycle after the write edge, unless bypass is compiled in.
- Debug latency 1 cycle. It reflects array contents before the same edge's write.
- Clear duration: exactly NUM_REGISTERS rising edges with reset low. clear_busy falls after the last one (32 edges at default).
- wr_err asserts 1 cycle after the offending edge and lasts 1 cycle. Back-to-back dropped writes keep it high.
- Outputs after reset edge: clear_busy=1, rdata=0, dbg_data=0, wr_err=0. Outputs before the first reset edge are undefined.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - In READY, a read port whose address equals waddr, with we=1 and 0 < waddr < NUM_REGISTERS, returns wdata combinationally in the same cycle.
  - All other masking rules still apply.
- Undefined: reads return the pre-write value until the write edge.
  - No combinational path from wdata or we to rdata.

## Test plan
- Reset 1 cycle, then release -> clear_busy high for exactly 32 edges, then low; all rdata 0 throughout.
- Preload registers with 0xFFFFFFFF, reset -> after clear completes, every address reads 0x00000000.
- READY, write 0xDEADBEEF to r5 -> raddr port0=5 and port1=5 both read 0xDEADBEEF the next cycle.
  - With REG_FILE_BYPASS_EN, the value also appears in the write cycle.
- Write 0x12345678 to r0 -> r0 reads 0; wr_err stays 0.
- we=1 during CLEAR (cnt=10) -> write dropped; wr_err=1 the next cycle.
  - NUM_REGISTERS=24, waddr=30 -> same response; r30 reads 0.
- Reset asserted at cnt=15 -> counter restarts; clear_busy stays high for 32 more edges after release.
- dbg_addr=5, with r5 written 0xA5A5A5A5 -> dbg_data=0xA5A5A5A5 one cycle after the write is visible.
